// File: rtl/shared_tlb_pkg.sv
// Shared core package: Sv39 widths, TLB entry record and FSM encoding.
// Also carries the CVA6 config value the shared TLB depth defaults from.
package shared_tlb_pkg;

    localparam int unsigned CVA6ConfigDataTlbEntries = 16;

    localparam int unsigned Sv39VpnWidth = 27;
    localparam int unsigned Sv39PpnWidth = 44;

    typedef struct packed {
        logic                    valid;
        logic [Sv39VpnWidth-1:0] vpn;
        logic [Sv39PpnWidth-1:0] ppn;
    } tlb_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

endpackage

// File: rtl/shared_tlb_rr_arb.sv
// Two-requester round-robin arbiter for the shared TLB lookup port.
// Bit 0 is the ITLB, bit 1 the DTLB; ITLB has priority after reset.
module shared_tlb_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic prio;

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (req[0] && (!req[1] || !prio)) begin
                gnt = 2'b01;
            end else if (req[1]) begin
                gnt = 2'b10;
            end
        end
    end

    // A grant is always a handshake, since grant implies request.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (gnt[0]) begin
            prio <= 1'b1;
        end else if (gnt[1]) begin
            prio <= 1'b0;
        end
    end

endmodule

// File: rtl/shared_tlb.sv
// Fully-associative shared L2 TLB serving ITLB and DTLB misses.
// One lookup outstanding; fills and flushes are independent of it.
module shared_tlb
    import shared_tlb_pkg::*;
#(
    parameter int unsigned NrEntries = CVA6ConfigDataTlbEntries,
    parameter int unsigned VpnWidth  = Sv39VpnWidth,
    parameter int unsigned PpnWidth  = Sv39PpnWidth
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                itlb_req_valid_i,
    output logic                itlb_req_ready_o,
    input  logic [VpnWidth-1:0] itlb_req_vpn_i,
    input  logic                dtlb_req_valid_i,
    output logic                dtlb_req_ready_o,
    input  logic [VpnWidth-1:0] dtlb_req_vpn_i,
    output logic                resp_valid_o,
    input  logic                resp_ready_i,
    output logic                resp_port_o,
    output logic                resp_hit_o,
    output logic [PpnWidth-1:0] resp_ppn_o,
    input  logic                fill_valid_i,
    input  logic [VpnWidth-1:0] fill_vpn_i,
    input  logic [PpnWidth-1:0] fill_ppn_i
);

    localparam int unsigned IdxWidth = $clog2(NrEntries);

    tlb_entry_t entries [NrEntries];

    logic [IdxWidth-1:0] ptr;
    state_e              state;
    state_e              state_n;
    logic                arb_en;
    logic [1:0]          gnt;
    logic                accept;

    logic [VpnWidth-1:0]  lk_vpn;
    logic [NrEntries-1:0] lk_match;
    logic                 lk_hit;
    logic [PpnWidth-1:0]  lk_ppn;
    logic [NrEntries-1:0] fill_match;
    logic                 fill_hit;

    shared_tlb_rr_arb u_arb (
        .clk    (clk_i),
        .rst    (rst_i),
        .enable (arb_en),
        .req    ({dtlb_req_valid_i, itlb_req_valid_i}),
        .gnt    (gnt)
    );

    assign accept           = |gnt;
    assign itlb_req_ready_o = gnt[0];
    assign dtlb_req_ready_o = gnt[1];
    assign lk_vpn = gnt[1] ? dtlb_req_vpn_i : itlb_req_vpn_i;

    // Lookup and fill search both see the pre-update array.
    always_comb begin
        lk_match   = '0;
        fill_match = '0;
        lk_ppn     = '0;
        for (int i = 0; i < NrEntries; i++) begin
            lk_match[i]   = entries[i].valid &&
                            (entries[i].vpn == lk_vpn);
            fill_match[i] = entries[i].valid &&
                            (entries[i].vpn == fill_vpn_i);
            if (lk_match[i]) begin
                lk_ppn = lk_ppn | entries[i].ppn;
            end
        end
        lk_hit = $onehot(lk_match);
        if (!lk_hit) begin
            lk_ppn = '0;
        end
    end

    assign fill_hit = |fill_match;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            for (int i = 0; i < NrEntries; i++) begin
                entries[i].valid <= 1'b0;
            end
            ptr <= '0;
        end else if (fill_valid_i) begin
            if (fill_hit) begin
                for (int i = 0; i < NrEntries; i++) begin
                    if (fill_match[i]) begin
                        entries[i].ppn <= fill_ppn_i;
                    end
                end
            end else begin
                entries[ptr].valid <= 1'b1;
                entries[ptr].vpn   <= fill_vpn_i;
                entries[ptr].ppn   <= fill_ppn_i;
                ptr                <= ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        arb_en  = 1'b0;
        unique case (state)
            IDLE: begin
                arb_en = 1'b1;
                if (accept) begin
                    state_n = RESP;
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_hit_o  <= 1'b0;
            resp_ppn_o  <= '0;
            resp_port_o <= 1'b0;
        end else if (accept) begin
            resp_hit_o  <= lk_hit;
            resp_ppn_o  <= lk_ppn;
            resp_port_o <= gnt[1];
        end
    end

    assign resp_valid_o = (state == RESP);

endmodule

// File: tb/tb_shared_tlb.sv
// Self-checking bench for shared_tlb: directed scenarios plus random
// traffic compared against a slot-array reference model.
module tb_shared_tlb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        iv = 1'b0;
    logic        ir;
    logic [26:0] ivpn = '0;
    logic        dv = 1'b0;
    logic        dr;
    logic [26:0] dvpn = '0;
    logic        rv;
    logic        rrdy = 1'b1;
    logic        rport;
    logic        rhit;
    logic [43:0] rppn;
    logic        fv = 1'b0;
    logic [26:0] fvpn = '0;
    logic [43:0] fppn = '0;

    int checks = 0;
    int errors = 0;

    bit          m_v   [16];
    logic [26:0] m_vpn [16];
    logic [43:0] m_ppn [16];
    int          m_ptr;
    bit          m_prio;
    bit          m_resp;
    bit          e_hit;
    bit          e_port;
    logic [43:0] e_ppn;
    bit          acc;

    always #5 clk = ~clk;

    shared_tlb dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .flush_i          (flush),
        .itlb_req_valid_i (iv),
        .itlb_req_ready_o (ir),
        .itlb_req_vpn_i   (ivpn),
        .dtlb_req_valid_i (dv),
        .dtlb_req_ready_o (dr),
        .dtlb_req_vpn_i   (dvpn),
        .resp_valid_o     (rv),
        .resp_ready_i     (rrdy),
        .resp_port_o      (rport),
        .resp_hit_o       (rhit),
        .resp_ppn_o       (rppn),
        .fill_valid_i     (fv),
        .fill_vpn_i       (fvpn),
        .fill_ppn_i       (fppn)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
        m_ptr = 0;
    endtask

    task automatic tick();
        bit wi;
        bit wd;
        int f;
        logic [26:0] v;
        #1;
        wi = 1'b0;
        wd = 1'b0;
        if (!m_resp) begin
            if (iv && dv) begin
                if (m_prio) wd = 1'b1;
                else wi = 1'b1;
            end else if (iv) begin
                wi = 1'b1;
            end else if (dv) begin
                wd = 1'b1;
            end
        end
        chk("itlb_ready", ir, wi);
        chk("dtlb_ready", dr, wd);
        acc = 1'b0;
        if (rst) begin
            model_clear();
            m_resp = 1'b0;
            m_prio = 1'b0;
        end else begin
            if (wi || wd) begin
                v = wd ? dvpn : ivpn;
                e_hit = 1'b0;
                e_ppn = '0;
                for (int i = 0; i < 16; i++) begin
                    if (m_v[i] && m_vpn[i] == v) begin
                        e_hit = 1'b1;
                        e_ppn = m_ppn[i];
                    end
                end
                e_port = wd;
                m_resp = 1'b1;
                m_prio = wi;
                acc = 1'b1;
            end else if (m_resp && rrdy) begin
                m_resp = 1'b0;
            end
            if (flush) begin
                model_clear();
            end else if (fv) begin
                f = -1;
                for (int i = 0; i < 16; i++)
                    if (m_v[i] && m_vpn[i] == fvpn) f = i;
                if (f >= 0) begin
                    m_ppn[f] = fppn;
                end else begin
                    m_v[m_ptr]   = 1'b1;
                    m_vpn[m_ptr] = fvpn;
                    m_ppn[m_ptr] = fppn;
                    m_ptr = (m_ptr + 1) % 16;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("resp_valid", rv, m_resp);
        if (m_resp) begin
            chk("resp_hit", rhit, e_hit);
            chk("resp_ppn", rppn, e_ppn);
            chk("resp_port", rport, e_port);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic fill(input logic [26:0] v, input logic [43:0] p);
        fv = 1'b1;
        fvpn = v;
        fppn = p;
        tick();
        fv = 1'b0;
    endtask

    task automatic req(input bit port, input logic [26:0] v);
        if (port) begin
            dv = 1'b1;
            dvpn = v;
        end else begin
            iv = 1'b1;
            ivpn = v;
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            if (acc) break;
        end
        chk("req_accepted", acc, 1'b1);
        if (port) dv = 1'b0;
        else iv = 1'b0;
    endtask

    initial begin
        int n_acc;
        m_resp = 1'b0;
        m_prio = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        chk("rst_resp_hit", rhit, 1'b0);
        chk("rst_resp_port", rport, 1'b0);
        chk("rst_resp_ppn", rppn, 44'h0);

        fill(27'h12345, 44'hABCDE);
        req(1'b1, 27'h12345);
        chk("d_hit", rhit, 1'b1);
        chk("d_port", rport, 1'b1);
        chk("d_ppn", rppn, 44'hABCDE);
        tick();

        do_reset();
        iv = 1'b1;
        dv = 1'b1;
        ivpn = 27'h1;
        dvpn = 27'h2;
        n_acc = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (rv && acc) begin
                chk("rr_order", rport, n_acc[0]);
                n_acc++;
            end
        end
        chk("rr_count", n_acc, 6);
        iv = 1'b0;
        dv = 1'b0;
        tick();

        do_reset();
        for (int v = 0; v <= 16; v++) fill(27'(v), 44'(32'h100 + v));
        for (int v = 0; v <= 16; v++) begin
            req(1'b0, 27'(v));
            chk("cap_hit", rhit, (v != 0));
            tick();
        end
        fill(27'd5, 44'h77);
        req(1'b0, 27'd5);
        chk("refill_ppn", rppn, 44'h77);
        tick();
        fill(27'd100, 44'h55);
        req(1'b1, 27'd1);
        chk("evict_1", rhit, 1'b0);
        tick();
        req(1'b1, 27'd2);
        chk("keep_2", rhit, 1'b1);
        tick();

        fill(27'h33, 44'h3);
        ivpn = 27'h33;
        iv = 1'b1;
        fv = 1'b1;
        fvpn = 27'h34;
        fppn = 44'h4;
        ivpn = 27'h34;
        tick();
        iv = 1'b0;
        fv = 1'b0;
        chk("same_cycle_miss", rhit, 1'b0);
        tick();
        req(1'b0, 27'h34);
        chk("fill_next_hit", rhit, 1'b1);
        tick();

        fv = 1'b1;
        fvpn = 27'h40;
        fppn = 44'h40;
        flush = 1'b1;
        tick();
        fv = 1'b0;
        flush = 1'b0;
        req(1'b0, 27'h40);
        chk("flush_fill_drop", rhit, 1'b0);
        tick();
        req(1'b0, 27'd2);
        chk("flush_old_miss", rhit, 1'b0);
        tick();

        fill(27'h9, 44'h99);
        rrdy = 1'b0;
        req(1'b1, 27'h9);
        iv = 1'b1;
        ivpn = 27'h9;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("stall_ppn", rppn, 44'h99);
        rrdy = 1'b1;
        for (int k = 0; k < 4 && !acc; k++) tick();
        chk("stall_release", acc, 1'b1);
        iv = 1'b0;
        tick();

        fill(27'h9, 44'h99);
        rrdy = 1'b0;
        req(1'b1, 27'h9);
        rst = 1'b1;
        tick();
        chk("rst_in_resp", rv, 1'b0);
        rst = 1'b0;
        rrdy = 1'b1;
        req(1'b0, 27'h9);
        chk("rst_clears", rhit, 1'b0);
        tick();

        for (int k = 0; k < 1500; k++) begin
            iv    = ($urandom_range(0, 99) < 50);
            dv    = ($urandom_range(0, 99) < 50);
            ivpn  = 27'($urandom_range(0, 23));
            dvpn  = 27'($urandom_range(0, 23));
            fv    = ($urandom_range(0, 99) < 30);
            fvpn  = 27'($urandom_range(0, 23));
            fppn  = 44'($urandom);
            flush = ($urandom_range(0, 99) < 2);
            rrdy  = ($urandom_range(0, 99) < 70);
            rst   = ($urandom_range(0, 999) < 5);
            tick();
        end
        rst = 1'b0;
        iv = 1'b0;
        dv = 1'b0;
        fv = 1'b0;
        flush = 1'b0;
        rrdy = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
